// File: rtl/or1k_wb_arbiter.sv
// or1k_wb_arbiter: round-robin Wishbone arbiter for NM masters onto one slave.
// Define OR1K_WB_ARB_WATCHDOG_EN to add a stalled-slave watchdog.
module or1k_wb_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NM         = 3,
  parameter int WDT_CYCLES = 256
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM*3-1:0]    m_cti_i,
  input  logic [NM*2-1:0]    m_bte_i,
  output logic [NM*DW-1:0]   m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic [NM-1:0]      m_rty_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  output logic               s_we_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_rty_i,
  output logic [NM-1:0]      grant_o
);
  localparam int LW = NM > 1 ? $clog2(NM) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]    state;
  logic [NM-1:0] grant;
  logic [LW-1:0] gidx, last, pick;
  logic          busy, wdt_hit;
  // Scan downward so the requester closest after last-granted is assigned last and wins.
  always_comb begin
    pick = last;
    for (int i = NM; i >= 1; i--) begin
      if (m_cyc_i[(int'(last) + i) % NM]) pick = LW'((int'(last) + i) % NM);
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= LW'(NM - 1);
    end else if (state == IDLE) begin
      if (|m_cyc_i) begin
        state <= BUSY;
        grant <= NM'(1) << pick;
        gidx  <= pick;
      end
    end else if (!m_cyc_i[gidx]) begin
      state <= IDLE;
      grant <= '0;
      last  <= gidx;
    end
  end
  assign busy    = state == BUSY;
  assign grant_o = grant;
  assign s_adr_o = m_adr_i[int'(gidx)*AW +: AW];
  assign s_dat_o = m_dat_i[int'(gidx)*DW +: DW];
  assign s_sel_o = m_sel_i[int'(gidx)*(DW/8) +: DW/8];
  assign s_cti_o = m_cti_i[int'(gidx)*3 +: 3];
  assign s_bte_o = m_bte_i[int'(gidx)*2 +: 2];
  assign s_we_o  = m_we_i[gidx];
  assign s_cyc_o = busy & m_cyc_i[gidx];
  assign s_stb_o = busy & m_stb_i[gidx];
  assign m_dat_o = {NM{s_dat_i}};
  assign m_ack_o = grant & {NM{s_ack_i}};
  assign m_err_o = grant & {NM{s_err_i | wdt_hit}};
  assign m_rty_o = grant & {NM{s_rty_i}};
`ifdef OR1K_WB_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDT_CYCLES + 1);
  logic [CW-1:0] wdt_cnt;
  assign wdt_hit = wdt_cnt == CW'(WDT_CYCLES);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !busy || s_ack_i || s_err_i || s_rty_i || wdt_hit) wdt_cnt <= '0;
    else if (s_stb_o) wdt_cnt <= wdt_cnt + 1'b1;
  end
`else
  assign wdt_hit = 1'b0;
`endif
endmodule

// File: tb/tb_or1k_wb_arbiter.sv
// tb_or1k_wb_arbiter: directed self-checking bench for or1k_wb_arbiter.
module tb_or1k_wb_arbiter;
  localparam int AW = 32, DW = 32, NM = 3;
  logic              wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic [NM*AW-1:0]  m_adr_i = '0;
  logic [NM*DW-1:0]  m_dat_i = '0;
  logic [NM*DW/8-1:0] m_sel_i = '0;
  logic [NM-1:0]     m_we_i = '0, m_cyc_i = '0, m_stb_i = '0;
  logic [NM*3-1:0]   m_cti_i = '0;
  logic [NM*2-1:0]   m_bte_i = '0;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i = '0;
  logic              s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  int checks = 0, errors = 0;

  or1k_wb_arbiter #(.AW(AW), .DW(DW), .NM(NM), .WDT_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_cyc", {30'd0, s_cyc_o, s_stb_o}, 0);
    chk("rst_resp", {23'd0, m_ack_o, m_err_o, m_rty_o}, 0);
    wb_rst_i = 1'b0;
    // single read by master 2, slave acks in the second BUSY cycle
    m_adr_i[95:64] = 32'h100;
    m_cyc_i[2] = 1'b1;
    m_stb_i[2] = 1'b1;
    #1;
    chk("arb_cycle_stb", 32'(s_stb_o), 0);
    chk("arb_cycle_grant", 32'(grant_o), 0);
    cyc();
    chk("m2_grant", 32'(grant_o), 32'b100);
    chk("m2_stb", {30'd0, s_cyc_o, s_stb_o}, 2'b11);
    chk("m2_adr", s_adr_o, 32'h100);
    cyc();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_F00D;
    #1;
    chk("m2_ack", 32'(m_ack_o), 32'b100);
    chk("m2_dat_bcast2", m_dat_o[95:64], 32'hCAFE_F00D);
    chk("m2_dat_bcast0", m_dat_o[31:0], 32'hCAFE_F00D);
    cyc();
    s_ack_i = 1'b0;
    m_cyc_i[2] = 1'b0;
    m_stb_i[2] = 1'b0;
    #1;
    chk("m2_drop_scyc", 32'(s_cyc_o), 0);
    cyc();
    chk("m2_idle", 32'(grant_o), 0);
    // simultaneous requests after reset: 0,1,2 with one idle cycle between
    wb_rst_i = 1'b1;
    cyc();
    wb_rst_i = 1'b0;
    m_cyc_i = 3'b111;
    m_stb_i = 3'b111;
    #1;
    chk("rr_arb", 32'(grant_o), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("rr_grant%0d", k), 32'(grant_o), 32'(1 << k));
      s_ack_i = 1'b1;
      #1;
      chk($sformatf("rr_ack%0d", k), 32'(m_ack_o), 32'(1 << k));
      cyc();
      s_ack_i = 1'b0;
      m_cyc_i[k] = 1'b0;
      m_stb_i[k] = 1'b0;
      cyc();
      chk($sformatf("rr_gap%0d", k), 32'(grant_o), 0);
    end
    // master 1 burst with master 2 waiting
    m_cyc_i = 3'b110;
    m_stb_i = 3'b110;
    m_cti_i[5:3] = 3'b010;
    cyc();
    chk("burst_grant", 32'(grant_o), 32'b010);
    chk("burst_cti", 32'(s_cti_o), 32'b010);
    for (int b = 0; b < 4; b++) begin
      m_cti_i[5:3] = b == 3 ? 3'b111 : 3'b010;
      s_ack_i = 1'b1;
      #1;
      chk($sformatf("burst_ack%0d", b), 32'(m_ack_o), 32'b010);
      chk($sformatf("burst_hold%0d", b), 32'(grant_o), 32'b010);
      cyc();
    end
    chk("burst_cti_end", 32'(s_cti_o), 32'b111);
    s_ack_i = 1'b0;
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    m_cti_i[5:3] = 3'b000;
    cyc();
    chk("burst_gap", 32'(grant_o), 0);
    cyc();
    chk("burst_next", 32'(grant_o), 32'b100);
    m_cyc_i[2] = 1'b0;
    m_stb_i[2] = 1'b0;
    cyc();
    // slave error routed only to master 1
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    cyc();
    chk("err_grant", 32'(grant_o), 32'b010);
    s_err_i = 1'b1;
    #1;
    chk("err_route", 32'(m_err_o), 32'b010);
    chk("err_noack", 32'(m_ack_o), 0);
    cyc();
    s_err_i = 1'b0;
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    cyc();
    // hung slave: master 0 granted, never acked
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    cyc();
    chk("hang_stb", 32'(s_stb_o), 1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
`ifdef OR1K_WB_ARB_WATCHDOG_EN
      chk($sformatf("wdt_err%0d", k), 32'(m_err_o), k == 16 ? 32'b001 : 32'b000);
`else
      chk($sformatf("hang_err%0d", k), 32'(m_err_o), 0);
`endif
    end
    chk("hang_grant", 32'(grant_o), 32'b001);
    // reset mid-write by master 0
    m_we_i[0] = 1'b1;
    m_dat_i[31:0] = 32'h1234_5678;
    m_sel_i[3:0] = 4'b1111;
    #1;
    chk("wr_we", 32'(s_we_o), 1);
    chk("wr_dat", s_dat_o, 32'h1234_5678);
    chk("wr_sel", 32'(s_sel_o), 32'hF);
    wb_rst_i = 1'b1;
    s_ack_i = 1'b1;
    cyc();
    chk("abort_cyc", 32'(s_cyc_o), 0);
    chk("abort_grant", 32'(grant_o), 0);
    chk("abort_ack", 32'(m_ack_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
